regfile_readback: RTL

Backchannel readback responder for the divider/pulse-generator design. Decodes command bytes arriving from the user UART receiver, then streams either the full register file (0xAB) or the last latched Thunderbolt timing packet (0xAC) out through the user UART transmitter, one byte per transmit handshake. It is the read-side counterpart to the SPI write path: SPI writes configuration into the register file, and this block reads it back through the regfile read port.

---
 rtl/regfile_readback.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/regfile_readback.sv
// regfile_readback
//   Backchannel readback responder. Decodes command bytes from the user UART
//   receiver and streams either the register file (CMD_REGS) or the last
//   latched Thunderbolt timing packet (CMD_THUNDER) out through the user UART
//   transmitter, one byte per transmit handshake.
//
// Ports
//   i_clk          system clock (10 MHz)
//   i_rst          synchronous active-high reset
//   i_rx_dv        one-cycle strobe, i_rx_byte valid
//   i_rx_byte      received command byte
//   o_rd           regfile read request, one-cycle pulse
//   o_rd_addr      regfile read address
//   i_rd_byte      regfile read data, valid the cycle after o_rd
//   i_thunder_dv   one-cycle strobe, i_thunder_data holds a new packet
//   i_thunder_data packet, byte 0 in the most significant byte
//   o_tx_dv        one-cycle strobe to start transmitting o_tx_byte
//   o_tx_byte      byte to transmit, stable from o_tx_dv until i_tx_done
//   i_tx_active    transmitter busy
//   i_tx_done      one-cycle strobe, current byte finished
//   o_busy         high whenever a dump is in progress
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a command byte
// RD_REQ  | regfile read request for address idx
// RD_WAIT | regfile data returning, captured into o_tx_byte
// TX_LOAD | waiting for the transmitter; thunder byte idx loaded here
// TX_WAIT | byte handed to transmitter, waiting for i_tx_done

module regfile_readback #(
    parameter int          FILE_SIZE_BYTES = 25,
    parameter int          THUNDER_BYTES   = 17,
    parameter logic [7:0]  CMD_REGS        = 8'hAB,
    parameter logic [7:0]  CMD_THUNDER     = 8'hAC
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rx_dv,
    input  logic [7:0]                 i_rx_byte,
    output logic                       o_rd,
    output logic [7:0]                 o_rd_addr,
    input  logic [7:0]                 i_rd_byte,
    input  logic                       i_thunder_dv,
    input  logic [8*THUNDER_BYTES-1:0] i_thunder_data,
    output logic                       o_tx_dv,
    output logic [7:0]                 o_tx_byte,
    input  logic                       i_tx_active,
    input  logic                       i_tx_done,
    output logic                       o_busy
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, TX_LOAD, TX_WAIT
    } state_t;

    state_t                     state, state_next;
    logic                       mode_thunder, mode_next;
    logic [7:0]                 idx, idx_next;
    logic                       tx_dv_next;
    logic [7:0]                 tx_byte_next;
    logic [8*THUNDER_BYTES-1:0] snapshot;
    logic [7:0]                 snap_byte;
    logic                       last_byte;

    assign o_rd      = (state == RD_REQ);
    assign o_rd_addr = idx;
    assign o_busy    = (state != IDLE);

    always_comb begin
        snap_byte = snapshot[8*(THUNDER_BYTES-1-int'(idx)) +: 8];
        last_byte = mode_thunder ? (idx == 8'(THUNDER_BYTES-1))
                                 : (idx == 8'(FILE_SIZE_BYTES-1));
    end

    always_comb begin
        state_next   = state;
        mode_next    = mode_thunder;
        idx_next     = idx;
        tx_dv_next   = 1'b0;
        tx_byte_next = o_tx_byte;
        case (state)
            IDLE: begin
                if (i_rx_dv) begin
                    if (i_rx_byte == CMD_REGS) begin
                        mode_next  = 1'b0;
                        idx_next   = 8'd0;
                        state_next = RD_REQ;
                    end else if (i_rx_byte == CMD_THUNDER) begin
                        mode_next  = 1'b1;
                        idx_next   = 8'd0;
                        state_next = TX_LOAD;
                    end
                end
            end
            RD_REQ: state_next = RD_WAIT;
            RD_WAIT: begin
                // The strobe is registered, so an idle transmitter is handed
                // the byte straight from here; otherwise park in TX_LOAD.
                tx_byte_next = i_rd_byte;
                if (!i_tx_active) begin
                    tx_dv_next = 1'b1;
                    state_next = TX_WAIT;
                end else begin
                    state_next = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (mode_thunder) tx_byte_next = snap_byte;
                if (!i_tx_active) begin
                    tx_dv_next = 1'b1;
                    state_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (i_tx_done) begin
                    if (last_byte) begin
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx + 8'd1;
                        state_next = mode_thunder ? TX_LOAD : RD_REQ;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            mode_thunder <= 1'b0;
            idx          <= 8'd0;
            o_tx_dv      <= 1'b0;
            o_tx_byte    <= 8'd0;
        end else begin
            state        <= state_next;
            mode_thunder <= mode_next;
            idx          <= idx_next;
            o_tx_dv      <= tx_dv_next;
            o_tx_byte    <= tx_byte_next;
        end
    end

    // Frozen during a thunder dump so the transmitted packet is self-consistent.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            snapshot <= '0;
        end else if (i_thunder_dv && !(mode_thunder && state != IDLE)) begin
            snapshot <= i_thunder_data;
        end
    end

endmodule
